// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 scancodes, direction one-hot encodings and decode-FSM states.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] KEY_W     = 8'h1D;
  localparam logic [7:0] KEY_S     = 8'h1B;
  localparam logic [7:0] KEY_A     = 8'h1C;
  localparam logic [7:0] KEY_D     = 8'h23;
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;

  localparam logic [3:0] DIR_UP    = 4'b1000;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;
  localparam logic [3:0] DIR_NONE  = 4'b0000;

  typedef enum logic [1:0] {StWait, StExt, StBrk, StExtBrk} dec_state_e;

  // Extended codes map arrows; plain codes map WASD. Anything else is DIR_NONE.
  function automatic logic [3:0] key_to_dir(input logic [7:0] code, input logic ext);
    logic [3:0] dir;
    dir = DIR_NONE;
    if (ext) begin
      case (code)
        KEY_UP:    dir = DIR_UP;
        KEY_DOWN:  dir = DIR_DOWN;
        KEY_LEFT:  dir = DIR_LEFT;
        KEY_RIGHT: dir = DIR_RIGHT;
        default:   dir = DIR_NONE;
      endcase
    end else begin
      case (code)
        KEY_W:   dir = DIR_UP;
        KEY_S:   dir = DIR_DOWN;
        KEY_A:   dir = DIR_LEFT;
        KEY_D:   dir = DIR_RIGHT;
        default: dir = DIR_NONE;
      endcase
    end
    return dir;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronizers, clock glitch filter, 11-bit frame FSM.
// Define PS2_TIMEOUT_EN to abort frames that stall for TIMEOUT_CYC clocks.
module ps2_frame_rx #(
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       err_o
);

  localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);

  typedef enum logic {StIdle, StData} rx_state_e;

  logic [1:0]       clk_sync_q, data_sync_q;
  logic             clk_filt_q, clk_filt_d;
  logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
  logic             fall, data, timeout;
  rx_state_e        state_q, state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  assign data = data_sync_q[1];

  always_comb begin
    clk_filt_d = clk_filt_q;
    filt_cnt_d = '0;
    if (clk_sync_q[1] != clk_filt_q) begin
      if (filt_cnt_q == FiltW'(FILTER_LEN - 1)) clk_filt_d = clk_sync_q[1];
      else                                       filt_cnt_d = filt_cnt_q + 1'b1;
    end
  end

  assign fall = clk_filt_q & ~clk_filt_d;

`ifdef PS2_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYC + 1);
  logic [ToW-1:0] to_cnt_q, to_cnt_d;

  assign to_cnt_d = (state_q == StData && !fall) ? to_cnt_q + 1'b1 : '0;
  assign timeout  = (state_q == StData) && (to_cnt_q == ToW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fall && !data) begin
          state_d   = StData;
          bit_cnt_d = '0;
          par_d     = 1'b0;
        end
      end
      StData: begin
        if (fall) begin
          if (bit_cnt_q < 4'd8) begin
            shift_d   = {data, shift_q[7:1]};
            par_d     = par_q ^ data;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (bit_cnt_q == 4'd8) begin
            par_d     = par_q ^ data;
            bit_cnt_d = 4'd9;
          end else begin
            // Stop bit: par_q now holds the XOR of data and parity, must be odd.
            state_d = StIdle;
            if (par_q && data) valid_d = 1'b1;
            else               err_d   = 1'b1;
          end
        end else if (timeout) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_filt_q  <= 1'b1;
      filt_cnt_q  <= '0;
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      clk_filt_q  <= clk_filt_d;
      filt_cnt_q  <= filt_cnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  assign byte_o       = shift_q;
  assign byte_valid_o = valid_q;
  assign err_o        = err_q;

endmodule

// File: rtl/ps2_direction_decoder.sv
// PS/2 keyboard to one-hot direction decoder (arrows and WASD, set-2 scancodes).
// Define PS2_TIMEOUT_EN to enable the mid-frame timeout in the receiver.
module ps2_direction_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [3:0] kb_direction,
  output logic       dir_valid,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_err;
  logic [3:0] k_plain, k_ext;

  dec_state_e state_q, state_d;
  logic [3:0] dir_q, dir_d;
  logic [7:0] scan_q, scan_d;
  logic       cv_q, cv_d, dv_q, dv_d, fe_q, fe_d;

  ps2_frame_rx #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .ps2_clk_i    (PS2_CLK),
    .ps2_data_i   (PS2_DATA),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .err_o        (rx_err)
  );

  assign k_plain = key_to_dir(rx_byte, 1'b0);
  assign k_ext   = key_to_dir(rx_byte, 1'b1);

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    scan_d  = scan_q;
    cv_d    = 1'b0;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
    if (rx_err) begin
      fe_d    = 1'b1;
      state_d = StWait;
    end else if (rx_valid) begin
      scan_d  = rx_byte;
      cv_d    = 1'b1;
      state_d = StWait;
      unique case (state_q)
        StWait: begin
          if (rx_byte == PS2_EXT)      state_d = StExt;
          else if (rx_byte == PS2_BRK) state_d = StBrk;
          else if (k_plain != DIR_NONE) dir_d = k_plain;
        end
        StExt: begin
          if (rx_byte == PS2_BRK)     state_d = StExtBrk;
          else if (k_ext != DIR_NONE) dir_d = k_ext;
        end
        // A release only clears if it names the direction currently held.
        StBrk:    if (k_plain != DIR_NONE && k_plain == dir_q) dir_d = DIR_NONE;
        StExtBrk: if (k_ext != DIR_NONE && k_ext == dir_q)     dir_d = DIR_NONE;
      endcase
      dv_d = (dir_d != dir_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StWait;
      dir_q   <= DIR_NONE;
      scan_q  <= 8'h00;
      cv_q    <= 1'b0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      scan_q  <= scan_d;
      cv_q    <= cv_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
    end
  end

  assign kb_direction = dir_q;
  assign dir_valid    = dv_q;
  assign scan_code    = scan_q;
  assign code_valid   = cv_q;
  assign frame_err    = fe_q;

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Directed bench for ps2_direction_decoder: bit-banged PS/2 frames, pulse counters.
module tb_ps2_direction_decoder;

  localparam int HALF   = 200;
  localparam int TB_TO  = 2000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       PS2_CLK;
  logic       PS2_DATA;
  logic [3:0] kb_direction;
  logic       dir_valid;
  logic [7:0] scan_code;
  logic       code_valid;
  logic       frame_err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cv_cnt = 0, dv_cnt = 0, fe_cnt = 0;
  int unsigned cv0, dv0, fe0;

  ps2_direction_decoder #(
    .FILTER_LEN  (4),
    .TIMEOUT_CYC (TB_TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .PS2_CLK      (PS2_CLK),
    .PS2_DATA     (PS2_DATA),
    .kb_direction (kb_direction),
    .dir_valid    (dir_valid),
    .scan_code    (scan_code),
    .code_valid   (code_valid),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (code_valid) cv_cnt <= cv_cnt + 1;
    if (dir_valid)  dv_cnt <= dv_cnt + 1;
    if (frame_err)  fe_cnt <= fe_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    cv0 = cv_cnt;
    dv0 = dv_cnt;
    fe0 = fe_cnt;
  endtask

  task automatic ps2_bit(input logic d);
    PS2_DATA = d;
    #(HALF) PS2_CLK = 1'b0;
    #(HALF) PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_good, input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par_good ? ~^b : ^b);
    ps2_bit(stop);
    PS2_DATA = 1'b1;
    #(HALF * 2);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b1, 1'b1);
  endtask

  initial begin
    rst_n    = 1'b0;
    PS2_CLK  = 1'b1;
    PS2_DATA = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_eq("rst_dir", kb_direction, 4'b0000);
    check_eq("rst_scan", scan_code, 8'h00);
    check_eq("rst_pulses", {code_valid, dir_valid, frame_err}, 3'b000);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // W press
    snap();
    send(8'h1D);
    check_eq("w_scan", scan_code, 8'h1D);
    check_eq("w_cv", cv_cnt - cv0, 1);
    check_eq("w_dir", kb_direction, 4'b1000);
    check_eq("w_dv", dv_cnt - dv0, 1);
    check_eq("w_fe", fe_cnt - fe0, 0);

    // Right arrow plus typematic repeat, then extended release
    snap();
    send(8'hE0); send(8'h74); send(8'hE0); send(8'h74);
    check_eq("right_dir", kb_direction, 4'b0001);
    check_eq("right_dv", dv_cnt - dv0, 1);
    check_eq("right_cv", cv_cnt - cv0, 4);
    snap();
    send(8'hE0); send(8'hF0); send(8'h74);
    check_eq("right_rel_dir", kb_direction, 4'b0000);
    check_eq("right_rel_dv", dv_cnt - dv0, 1);

    // Newest press overrides; stale release ignored
    send(8'h1C);
    check_eq("a_dir", kb_direction, 4'b0010);
    send(8'h23);
    check_eq("d_dir", kb_direction, 4'b0001);
    snap();
    send(8'hF0); send(8'h1C);
    check_eq("stale_rel_dir", kb_direction, 4'b0001);
    check_eq("stale_rel_dv", dv_cnt - dv0, 0);
    send(8'hF0); send(8'h23);
    check_eq("d_rel_dir", kb_direction, 4'b0000);

    // Parity error leaves state untouched
    send(8'h1D);
    snap();
    send_frame(8'h23, 1'b0, 1'b1);
    check_eq("par_fe", fe_cnt - fe0, 1);
    check_eq("par_cv", cv_cnt - cv0, 0);
    check_eq("par_dir", kb_direction, 4'b1000);
    check_eq("par_scan", scan_code, 8'h1D);
    send(8'h1B);
    check_eq("s_dir", kb_direction, 4'b0100);

    // Stop-bit error
    snap();
    send_frame(8'h1C, 1'b1, 1'b0);
    check_eq("stop_fe", fe_cnt - fe0, 1);
    check_eq("stop_dir", kb_direction, 4'b0100);

    // Error after E0 drops back to WAIT, so 74 alone is not a key
    snap();
    send(8'hE0);
    send_frame(8'h6B, 1'b0, 1'b1);
    send(8'h74);
    check_eq("e0err_dir", kb_direction, 4'b0100);
    check_eq("e0err_scan", scan_code, 8'h74);
    check_eq("e0err_fe", fe_cnt - fe0, 1);

    // Arrow press released by WASD equivalent
    send(8'hE0); send(8'h6B);
    check_eq("larrow_dir", kb_direction, 4'b0010);
    send(8'hF0); send(8'h1C);
    check_eq("equiv_rel_dir", kb_direction, 4'b0000);

    // Lone clock edge with data high in idle is ignored
    snap();
    ps2_bit(1'b1);
    #(HALF * 2);
    send(8'h1D);
    check_eq("idle_edge_fe", fe_cnt - fe0, 0);
    check_eq("idle_edge_cv", cv_cnt - cv0, 1);
    check_eq("idle_edge_dir", kb_direction, 4'b1000);

`ifdef PS2_TIMEOUT_EN
    snap();
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    repeat (TB_TO + 100) @(posedge clk);
    check_eq("to_fe", fe_cnt - fe0, 1);
    check_eq("to_cv", cv_cnt - cv0, 0);
    send(8'h1C);
    check_eq("to_next_dir", kb_direction, 4'b0010);
`endif

    // Reset in the middle of a frame
    snap();
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    rst_n = 1'b0;
    #3;
    check_eq("mid_rst_dir", kb_direction, 4'b0000);
    check_eq("mid_rst_scan", scan_code, 8'h00);
    check_eq("mid_rst_pulses", {code_valid, dir_valid, frame_err}, 3'b000);
    PS2_CLK  = 1'b1;
    PS2_DATA = 1'b1;
    repeat (3) @(posedge clk);
    rst_n = 1'b1;
    #(HALF * 4);
    check_eq("mid_rst_cv", cv_cnt - cv0, 0);
    check_eq("mid_rst_fe", fe_cnt - fe0, 0);
    send(8'h23);
    check_eq("post_rst_dir", kb_direction, 4'b0001);
    check_eq("post_rst_scan", scan_code, 8'h23);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
